// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Gshare direction predictor plus direct-mapped BTB for the IF stage.
//   IF predictions are carried through IF/ID and ID/EX shadow registers so the
//   EX stage can train the tables with the index and prediction that were used
//   at fetch time.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   IF_pc                    fetch PC
//   stall                    load-use stall (holds IF/ID, bubbles ID/EX)
//   IF_flush, ID_flush       clear IF/ID resp. ID/EX shadow
//   EX_op, EX_pc             opcode and PC of the instruction in EX
//   EX_target                resolved taken target
//   EX_actual_taken          resolved branch direction
//   IF_gbc_predict_taken     PHT counter MSB at the IF index
//   IF_btb_b_hit/_j_hit      BTB hit on a branch / JAL entry
//   IF_btb_target            BTB target, 0 on miss
//   EX_gbc_predict_taken,
//   EX_btb_b_hit/_j_hit      IF predictions carried to EX
//   branch_cnt               trained B-type count (wraps)
//   mispredict_cnt           B-type mispredict count (wraps)
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int unsigned PHT_IDX_BITS = 6,
    parameter int unsigned GHR_BITS     = 6,
    parameter int unsigned BTB_IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_pc,
    input  logic        stall,
    input  logic        IF_flush,
    input  logic        ID_flush,
    input  logic [6:0]  EX_op,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_target,
    input  logic        EX_actual_taken,
    output logic        IF_gbc_predict_taken,
    output logic        IF_btb_b_hit,
    output logic        IF_btb_j_hit,
    output logic [31:0] IF_btb_target,
    output logic        EX_gbc_predict_taken,
    output logic        EX_btb_b_hit,
    output logic        EX_btb_j_hit,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int unsigned PHT_N = 1 << PHT_IDX_BITS;
    localparam int unsigned BTB_N = 1 << BTB_IDX_BITS;
    localparam int unsigned TAG_W = 32 - BTB_IDX_BITS - 2;

    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        BTB_BRANCH = 1'b0,
        BTB_JUMP   = 1'b1
    } btb_kind_e;

    typedef struct packed {
        logic                    taken;
        logic                    b_hit;
        logic                    j_hit;
        logic [PHT_IDX_BITS-1:0] pidx;
    } shadow_t;

    // Table storage
    logic [1:0]           pht_q       [PHT_N];
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic                 btb_valid_q [BTB_N];
    logic [TAG_W-1:0]     btb_tag_q   [BTB_N];
    btb_kind_e            btb_kind_q  [BTB_N];
    logic [31:0]          btb_tgt_q   [BTB_N];

    shadow_t              ifid_q, ifid_d;
    shadow_t              idex_q, idex_d;
    logic [31:0]          bcnt_q, bcnt_d;
    logic [31:0]          mcnt_q, mcnt_d;

    // IF lookup
    logic [PHT_IDX_BITS-1:0] ghr_ext;
    logic [PHT_IDX_BITS-1:0] if_pidx;
    logic [BTB_IDX_BITS-1:0] if_bidx;
    logic [TAG_W-1:0]        if_tag;
    logic                    if_hit;

    // EX training
    logic [BTB_IDX_BITS-1:0] ex_bidx;
    logic [TAG_W-1:0]        ex_tag;
    logic                    ex_is_b;
    logic                    ex_is_jal;
    logic [1:0]              pht_cur;
    logic [1:0]              pht_nxt;
    logic                    btb_wr_en;
    btb_kind_e               btb_wr_kind;

    // Byte-offset PC bits never participate in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{IF_pc[1:0], EX_pc[1:0]};

    always_comb begin
        ghr_ext                  = '0;
        ghr_ext[GHR_BITS-1:0]    = ghr_q;
        if_pidx                  = IF_pc[PHT_IDX_BITS+1:2] ^ ghr_ext;
        if_bidx                  = IF_pc[BTB_IDX_BITS+1:2];
        if_tag                   = IF_pc[31:BTB_IDX_BITS+2];
        if_hit                   = btb_valid_q[if_bidx] && (btb_tag_q[if_bidx] == if_tag);

        IF_gbc_predict_taken     = pht_q[if_pidx][1];
        IF_btb_b_hit             = if_hit && (btb_kind_q[if_bidx] == BTB_BRANCH);
        IF_btb_j_hit             = if_hit && (btb_kind_q[if_bidx] == BTB_JUMP);
        IF_btb_target            = if_hit ? btb_tgt_q[if_bidx] : '0;
    end

    // Shadow pipe: flush beats stall on IF/ID; stall turns ID/EX into a bubble.
    always_comb begin
        if (IF_flush) begin
            ifid_d = '0;
        end else if (stall) begin
            ifid_d = ifid_q;
        end else begin
            ifid_d.taken = IF_gbc_predict_taken;
            ifid_d.b_hit = IF_btb_b_hit;
            ifid_d.j_hit = IF_btb_j_hit;
            ifid_d.pidx  = if_pidx;
        end

        if (ID_flush || stall) begin
            idex_d = '0;
        end else begin
            idex_d = ifid_q;
        end
    end

    // Training uses the index carried from fetch, not one recomputed from EX_pc.
    always_comb begin
        ex_bidx   = EX_pc[BTB_IDX_BITS+1:2];
        ex_tag    = EX_pc[31:BTB_IDX_BITS+2];
        ex_is_b   = (EX_op == OP_B_TYPE);
        ex_is_jal = (EX_op == OP_JAL);

        pht_cur = pht_q[idex_q.pidx];
        pht_nxt = pht_cur;
        if (EX_actual_taken) begin
            if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
        end else begin
            if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
        end

        ghr_d  = ghr_q;
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (ex_is_b) begin
            ghr_d    = ghr_q << 1;
            ghr_d[0] = EX_actual_taken;
            bcnt_d   = bcnt_q + 32'd1;
            // A branch only counts as predicted taken if the BTB also supplied a target.
            if ((idex_q.taken & idex_q.b_hit) != EX_actual_taken) begin
                mcnt_d = mcnt_q + 32'd1;
            end
        end

        btb_wr_en   = ex_is_jal || (ex_is_b && EX_actual_taken);
        btb_wr_kind = ex_is_jal ? BTB_JUMP : BTB_BRANCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_N; i++) begin
                pht_q[PHT_IDX_BITS'(i)] <= 2'b01;
            end
            for (int unsigned j = 0; j < BTB_N; j++) begin
                btb_valid_q[BTB_IDX_BITS'(j)] <= 1'b0;
                btb_tag_q[BTB_IDX_BITS'(j)]   <= '0;
                btb_kind_q[BTB_IDX_BITS'(j)]  <= BTB_BRANCH;
                btb_tgt_q[BTB_IDX_BITS'(j)]   <= '0;
            end
            ghr_q  <= '0;
            ifid_q <= '0;
            idex_q <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (ex_is_b) begin
                pht_q[idex_q.pidx] <= pht_nxt;
            end
            // Direct-mapped: a write simply replaces whatever tag lived there.
            if (btb_wr_en) begin
                btb_valid_q[ex_bidx] <= 1'b1;
                btb_tag_q[ex_bidx]   <= ex_tag;
                btb_kind_q[ex_bidx]  <= btb_wr_kind;
                btb_tgt_q[ex_bidx]   <= EX_target;
            end
            ghr_q  <= ghr_d;
            ifid_q <= ifid_d;
            idex_q <= idex_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign EX_gbc_predict_taken = idex_q.taken;
    assign EX_btb_b_hit         = idex_q.b_hit;
    assign EX_btb_j_hit         = idex_q.j_hit;
    assign branch_cnt           = bcnt_q;
    assign mispredict_cnt       = mcnt_q;

endmodule
